// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, default latencies, counter width and the result bundle.
package e_mdu_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } md_result_t;

  // Two's-complement magnitude when the value is treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational datapath: 64-bit product or quotient/remainder pair,
// selected by the op code, plus a divide-by-zero flag.
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_result_t  res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_signed;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] b_safe;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] quot;
  logic        [31:0] rem;
  logic               q_neg;
  logic               r_neg;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Division on magnitudes sidesteps the INT_MIN / -1 overflow corner:
  // 0x80000000 / 1 yields 0x80000000 and the signs cancel.
  assign div_signed = (op == MD_DIV);
  assign a_mag      = mag32(a, div_signed);
  assign b_mag      = mag32(b, div_signed);
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign q_neg      = div_signed & (a[31] ^ b[31]);
  assign r_neg      = div_signed & a[31];
  assign quot       = q_neg ? (~q_mag + 32'd1) : q_mag;
  assign rem        = r_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = '{hi: prod_s[63:32], lo: prod_s[31:0], dz: 1'b0};
      MD_MULTU: res = '{hi: prod_u[63:32], lo: prod_u[31:0], dz: 1'b0};
      default:  res = '{hi: rem, lo: quot, dz: (b == 32'd0)};
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, holds the computed
// result in pending registers and commits it after a fixed busy period.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HIRead,
  input  logic        LORead,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam cnt_t MULT_CNT = cnt_t'(MULT_CYCLES);
  localparam cnt_t DIV_CNT  = cnt_t'(DIV_CYCLES);

  md_result_t  arith_res;
  md_result_t  pend_reg;
  cnt_t        count_reg;
  logic [0:0]  state_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  e_mdu_arith u_arith (
    .op  (MDOp),
    .a   (A),
    .b   (B),
    .res (arith_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      pend_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Start takes precedence over mthi/mtlo in the same cycle.
          if (Start) begin
            pend_reg  <= arith_res;
            count_reg <= MDOp[1] ? DIV_CNT : MULT_CNT;
            state_reg <= ST_BUSY;
          end else begin
            if (HIWrite) hi_reg <= A;
            if (LOWrite) lo_reg <= A;
          end
        end
        default: begin
          count_reg <= count_reg - cnt_t'(1);
          if (count_reg == cnt_t'(1)) begin
            state_reg <= ST_IDLE;
            if (!pend_reg.dz) begin
              hi_reg <= pend_reg.hi;
              lo_reg <= pend_reg.lo;
            end
          end
        end
      endcase
    end
  end

  assign Busy = (state_reg == ST_BUSY);
  assign Out  = HIRead ? hi_reg : (LORead ? lo_reg : 32'd0);

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO and latency are queued when an
// op starts and compared once Busy falls.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  MDOp = 2'b00;
  logic        HIWrite = 1'b0;
  logic        LOWrite = 1'b0;
  logic        HIRead = 1'b0;
  logic        LORead = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic [31:0] Out;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  e_mdu dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDOp    (MDOp),
    .HIWrite (HIWrite),
    .LOWrite (LOWrite),
    .HIRead  (HIRead),
    .LORead  (LORead),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Out     (Out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads stay within one clock phase (edge+1 .. edge+4).
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    HIRead = 1'b1; LORead = 1'b0; #1 hi = Out;
    HIRead = 1'b0; LORead = 1'b1; #1 lo = Out;
    LORead = 1'b0; #1;
  endtask

  task automatic start_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int cyc);
    exp_t e;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.cycles = cyc;
    sb.push_back(e);
    Start = 1'b1; MDOp = op; A = a; B = b;
    tick();
    Start = 1'b0;
  endtask

  task automatic finish_op(input int elapsed);
    int          n;
    exp_t        e;
    logic [31:0] hi, lo;
    n = elapsed;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      read_hilo(hi, lo);
      check({e.tag, "_busy"}, 32'(n), 32'(e.cycles));
      check({e.tag, "_hi"}, hi, e.hi);
      check({e.tag, "_lo"}, lo, e.lo);
      $display("txn %s busy=%0d hi=0x%08h lo=0x%08h", e.tag, n, hi, lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hi, lo;

    // Reset state
    tick();
    check("rst_busy", 32'(Busy), 32'd0);
    read_hilo(hi, lo);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // mthi + mtlo together, then read priority/zero
    HIWrite = 1'b1; LOWrite = 1'b1; A = 32'h0000ABCD;
    tick();
    HIWrite = 1'b0; LOWrite = 1'b0; A = '0;
    HIRead = 1'b1; LORead = 1'b1; #1 check("mt_hi_prio", Out, 32'h0000ABCD);
    HIRead = 1'b0; #1 check("mt_lo", Out, 32'h0000ABCD);
    LORead = 1'b0; #1 check("mt_none", Out, 32'd0);
    $display("txn mthi_mtlo a=0x0000abcd");
    tick();

    start_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    finish_op(0);
    start_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
    finish_op(0);
    start_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    finish_op(0);
    start_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    finish_op(0);

    // Divide by zero leaves preloaded HI/LO intact
    HIWrite = 1'b1; A = 32'h11; tick(); HIWrite = 1'b0;
    LOWrite = 1'b1; A = 32'h22; tick(); LOWrite = 1'b0;
    start_op("div0", MD_DIV, 32'd1234, 32'd0, 32'h11, 32'h22, 10);
    finish_op(0);

    start_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
    finish_op(0);

    // Start and mtlo/mthi during Busy are ignored; Out shows old values
    start_op("busy_ign", MD_MULT, 32'd100, 32'd7, 32'd0, 32'd700, 5);
    tick();
    Start = 1'b1; MDOp = MD_DIV; A = 32'h55; B = 32'd3; HIWrite = 1'b1; LOWrite = 1'b1;
    LORead = 1'b1; #1 check("busy_old_lo", Out, 32'h80000000);
    LORead = 1'b0;
    tick();
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    finish_op(2);

    // Start beats HIWrite in the same cycle
    HIWrite = 1'b1;
    start_op("start_wins", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 5);
    HIWrite = 1'b0;
    HIRead = 1'b1; #1 check("start_wins_midhi", Out, 32'd0);
    HIRead = 1'b0;
    finish_op(0);

    // Asynchronous reset mid-divide (count=4) aborts with no commit
    HIWrite = 1'b1; A = 32'h77; tick(); HIWrite = 1'b0;
    Start = 1'b1; MDOp = MD_DIVU; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(Busy), 32'd0);
    read_hilo(hi, lo);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("post_rst_busy", 32'(Busy), 32'd0);
    read_hilo(hi, lo);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);
    $display("txn reset_mid_div hi=0x%08h lo=0x%08h", hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the pipelined MIPS CPU.
- Consumes the E-stage control and operands held by the decode-to-execute pipeline register: Start, HIWrite, LOWrite, HIRead, LORead, forwarded RD1/RD2, and an op selector.
- Owns the architectural HI/LO registers and models multi-cycle latency with a Busy flag. The hazard unit uses Busy to stall the D stage.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu
DIV_CYCLES, 10, busy cycles for div/divu

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
Start  input  1  E-stage instruction is mult/multu/div/divu
MDOp  input  2  00 mult, 01 multu, 10 div, 11 divu; valid when Start=1
HIWrite  input  1  mthi in E
LOWrite  input  1  mtlo in E
HIRead  input  1  mfhi in E
LORead  input  1  mflo in E
A  input  32  forwarded rs operand
B  input  32  forwarded rt operand
Busy  output  1  operation in flight
Out  output  32  HI if HIRead, else LO if LORead, else 0

Behaviour:
Reset:
- Asserting reset (reset=0) immediately and asynchronously clears HI, LO, the pending-result regs, the counter and Busy.
- Reset mid-operation aborts the operation; no commit.

Idle (Busy=0, count=0):
- Start=1 at edge k: compute the result from A/B/MDOp and latch it into pending regs. Load count with MULT_CYCLES or DIV_CYCLES per MDOp[1].
- Busy=1 from edge k through the last busy cycle.

Busy:
- count decrements each edge.
- At the edge where count goes 1→0, commit pending HI/LO and drop Busy.
- Busy is therefore high for exactly N cycles after the Start cycle.
- Committed values are visible through Out on the first cycle Busy=0.

Start handling:
- The hazard unit stalls while Start|Busy and an MD instruction is in D, so Start never overlaps Busy.
- If Start is seen with Busy=1, it is ignored: no restart, no change to count.

mthi/mtlo:
- When Busy=0, HIWrite loads HI←A and LOWrite loads LO←A at the edge.
- Both may be set in the same cycle; both registers update.
- Ignored when Busy=1.
- If Start and HIWrite/LOWrite are both set in one cycle, Start wins.

Arithmetic:
- mult: {HI,LO} = signed A × signed B, 64-bit.
- multu: {HI,LO} = unsigned A × unsigned B, 64-bit.
- div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0): still busy DIV_CYCLES; HI/LO unchanged at commit.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

Out:
- Combinational from architectural HI/LO, never from pending regs.
- HIRead has priority over LORead.
- A read during Busy is prevented by the stall; if it occurs, Out returns the old value.

Decomposition:
- Shared package holds:
  - MDOp encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - Default cycle constants.
  - Counter width: 4 bits, enough for 10.
- One natural sub-module, e_mdu_arith: combinational 64-bit product, quotient, remainder and divide-by-zero flag selected by MDOp.
- The top-level block holds the counter/FSM, the pending regs and HI/LO.

Test Plan:
- Reset low mid-div (count=4) → Busy=0, HI=LO=0 immediately; no commit after reset release.
- mult A=0xFFFFFFFE, B=3 → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands → HI=2, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → Busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); divu A=7, B=2 → LO=3, HI=1.
- HI=0x11, LO=0x22 preloaded by mthi/mtlo, then div by B=0 → after 10 cycles HI=0x11, LO=0x22.
- During Busy, assert Start with new operands and LOWrite with A=0x55 → neither has an effect; the original result commits on schedule.
- Idle with HIWrite=LOWrite=1, A=0xABCD → next cycle HIRead gives Out=0xABCD; LORead gives 0xABCD; with both reads low, Out=0.
